// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmitter state encoding, keyboard command
// bytes and the falling-edge numbers that delimit the host-to-device frame.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    FINISH
  } ps2_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  localparam logic [3:0] LAST_DATA_FE = 4'd8;
  localparam logic [3:0] PARITY_FE    = 4'd9;
  localparam logic [3:0] STOP_FE      = 4'd10;
  localparam logic [3:0] ACK_FE       = 4'd11;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Synchronizes raw PS/2 clock/data pad levels and flags clock falling edges.
// fe is a one-cycle pulse SYNC_STAGES+1 cycles after the pad clock falls.
module ps2_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic fe
);

  logic [SYNC_STAGES-1:0] clk_pipe;
  logic [SYNC_STAGES-1:0] data_pipe;
  logic                   clk_prev;

  // Idle bus level is high (pull-ups), so the chains reset to ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_pipe  <= '1;
      data_pipe <= '1;
      clk_prev  <= 1'b1;
      fe        <= 1'b0;
    end else begin
      clk_pipe[0]  <= ps2_clk_in;
      data_pipe[0] <= ps2_data_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        clk_pipe[i]  <= clk_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
      clk_prev <= clk_pipe[SYNC_STAGES-1];
      fe       <= clk_prev & ~clk_pipe[SYNC_STAGES-1];
    end
  end

  assign clk_sync  = clk_pipe[SYNC_STAGES-1];
  assign data_sync = data_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 8N+odd
// parity frame, device ACK). Define PS2_TX_ACK_CHECK_EN to report NACK as error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_DATA = CNT_W'(INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic clk_sync;
  logic data_sync;
  logic fe;

  ps2_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .clk_sync   (clk_sync),
    .data_sync  (data_sync),
    .fe         (fe)
  );

  ps2_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       byte_q, byte_n;
  logic             parity_q, parity_n;
  logic             clk_oe_n, data_oe_n, busy_n, done_n, error_n;
`ifdef PS2_TX_ACK_CHECK_EN
  logic             ack_ok, ack_ok_n;
`else
  logic             ack_unused;
  assign ack_unused = data_sync;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      byte_q      <= '0;
      parity_q    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_ok      <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_cnt     <= bit_cnt_n;
      byte_q      <= byte_n;
      parity_q    <= parity_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      busy        <= busy_n;
      done        <= done_n;
      error       <= error_n;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_ok      <= ack_ok_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    byte_n    = byte_q;
    parity_n  = parity_q;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    busy_n    = busy;
    done_n    = 1'b0;
    error_n   = error;
`ifdef PS2_TX_ACK_CHECK_EN
    ack_ok_n  = ack_ok;
`endif

    unique case (state)
      IDLE: begin
        if (send) begin
          byte_n    = tx_data;
          parity_n  = odd_parity(tx_data);
          busy_n    = 1'b1;
          error_n   = 1'b0;
          clk_oe_n  = 1'b1;
          data_oe_n = 1'b0;
          cnt_n     = '0;
          bit_cnt_n = '0;
`ifdef PS2_TX_ACK_CHECK_EN
          ack_ok_n  = 1'b0;
`endif
          state_n   = INHIBIT;
        end
      end

      INHIBIT: begin
        // Start bit goes low one cycle before the clock is released.
        if (cnt == INH_LAST) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          cnt_n     = '0;
          state_n   = RTS;
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt == INH_DATA) data_oe_n = 1'b1;
        end
      end

      RTS, SHIFT, ACK: begin
        if (fe && state != ACK) begin
          // fe wins over a coincident timeout terminal count.
          cnt_n     = '0;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt < LAST_DATA_FE) begin
            data_oe_n = ~byte_q[bit_cnt[2:0]];
            state_n   = SHIFT;
          end else if (bit_cnt == LAST_DATA_FE) begin
            data_oe_n = ~parity_q;
          end else begin
            data_oe_n = 1'b0;
            state_n   = ACK;
          end
        end else if (fe && bit_cnt < ACK_FE) begin
          cnt_n     = '0;
          bit_cnt_n = ACK_FE;
`ifdef PS2_TX_ACK_CHECK_EN
          ack_ok_n  = ~data_sync;
`endif
        end else if (state == ACK && bit_cnt == ACK_FE && clk_sync) begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
          error_n = ~ack_ok;
`else
          error_n = 1'b0;
`endif
          state_n = FINISH;
        end else if (cnt == TO_LAST) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          done_n    = 1'b1;
          busy_n    = 1'b0;
          error_n   = 1'b1;
          state_n   = FINISH;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      FINISH: begin
        cnt_n   = '0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx with an open-drain pad model and a
// behavioural keyboard that clocks frames and records the bits it reads.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH  = 40;
  localparam int unsigned TO   = 800;
  localparam int unsigned SS   = 2;
  localparam int unsigned HALF = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [7:0] tx_data;
  logic       dev_clk, dev_data;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       busy, done, error;

  always #5 clk = ~clk;

  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data    (tx_data),
    .send       (send),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Observer sampling 1 time unit after each rising edge.
  int   cyc = 0, done_cnt = 0, inh_len = 0, inh_run = 0, t_rel = 0, t_done = 0;
  logic clk_oe_prev = 1'b0;
  logic err_at_done, busy_at_done, clk_oe_at_done, data_oe_at_done;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (ps2_clk_oe) inh_run++;
    else if (clk_oe_prev) begin
      inh_len = inh_run;
      inh_run = 0;
      t_rel   = cyc;
    end
    clk_oe_prev = ps2_clk_oe;
    if (done) begin
      done_cnt++;
      t_done          = cyc;
      err_at_done     = error;
      busy_at_done    = busy;
      clk_oe_at_done  = ps2_clk_oe;
      data_oe_at_done = ps2_data_oe;
    end
  end

  // Expected line levels: start 0, data LSB first, odd parity, stop released.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction

  task automatic pulse_send(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    send    = 1'b1;
    @(negedge clk);
    send    = 1'b0;
  endtask

  task automatic dev_frame(input int n_fe, input logic ack_level, output logic [10:0] line);
    int k = 0;
    line = '1;
    while (!(busy && !ps2_clk_oe && ps2_data_oe) && k < int'(INH) + 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("rts_seen", 32'(k < int'(INH) + 50), 32'd1);
    if (k >= int'(INH) + 50) return;
    line[0] = ps2_data_in;
    repeat (HALF) @(negedge clk);
    for (int i = 1; i <= n_fe; i++) begin
      if (i == 11) dev_data = ack_level;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (i <= 10) line[i] = ps2_data_in;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i == 11) dev_data = 1'b1;
    end
  endtask

  task automatic wait_done(input int start, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (done_cnt != start) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic run_txn(input logic [7:0] b, input logic ack_level, input logic exp_err,
                         input string tag);
    int          start = done_cnt;
    bit          ok;
    logic [10:0] line;
    pulse_send(b);
    dev_frame(11, ack_level, line);
    wait_done(start, 200, ok);
    check_eq({tag, "_done_seen"}, 32'(ok), 32'd1);
    check_eq({tag, "_frame"}, 32'(line), 32'(ref_frame(b)));
    check_eq({tag, "_inhibit_len"}, 32'(inh_len), INH);
    check_eq({tag, "_error"}, 32'(err_at_done), 32'(exp_err));
    check_eq({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    check_eq({tag, "_done_pulses"}, 32'(done_cnt - start), 32'd1);
  endtask

  initial begin
    int          start;
    bit          ok;
    logic [7:0]  b;
    logic [10:0] line;
    logic        nack_err;

`ifdef PS2_TX_ACK_CHECK_EN
    nack_err = 1'b1;
`else
    nack_err = 1'b0;
`endif

    rst = 1'b1; send = 1'b1; tx_data = PS2_CMD_RESET; dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", 32'({ps2_clk_oe, ps2_data_oe, busy, done, error}), 32'd0);
    send = 1'b0;
    rst  = 1'b0;
    @(negedge clk);

    run_txn(PS2_CMD_SET_LEDS, 1'b0, 1'b0, "ed");
    run_txn(8'h00, 1'b0, 1'b0, "b00");
    run_txn(8'h01, 1'b0, 1'b0, "b01");
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom_range(0, 255));
      run_txn(b, 1'b0, 1'b0, "rand");
    end

    // Device never answers the request-to-send.
    start = done_cnt;
    pulse_send(PS2_CMD_RESET);
    wait_done(start, int'(INH + TO) + 100, ok);
    check_eq("to_done_seen", 32'(ok), 32'd1);
    check_eq("to_error", 32'(err_at_done), 32'd1);
    check_eq("to_lines_released", 32'({clk_oe_at_done, data_oe_at_done}), 32'd0);
    check_eq("to_latency", 32'(t_done - t_rel), TO);
    repeat (5) @(negedge clk);
    check_eq("to_error_held", 32'({error, busy}), 32'b10);

    // Device leaves data released on the acknowledge clock.
    run_txn(8'($urandom_range(0, 255)), 1'b1, nack_err, "nack");
    run_txn(PS2_CMD_ECHO, 1'b0, 1'b0, "after_nack");

    // A second send during the frame must not disturb it.
    start = done_cnt;
    pulse_send(PS2_CMD_SET_LEDS);
    fork
      dev_frame(11, 1'b0, line);
      begin
        repeat (INH + HALF * 8) @(negedge clk);
        check_eq("busy_mid_frame", 32'(busy), 32'd1);
        tx_data = 8'h55;
        send    = 1'b1;
        @(negedge clk);
        send    = 1'b0;
      end
    join
    wait_done(start, 200, ok);
    check_eq("resend_frame", 32'(line), 32'(ref_frame(PS2_CMD_SET_LEDS)));
    check_eq("resend_error", 32'(err_at_done), 32'd0);
    repeat (20) @(negedge clk);
    check_eq("resend_no_queue", 32'({busy, 6'(done_cnt - start)}), 32'd1);

    // Reset in the middle of the data bits.
    start = done_cnt;
    pulse_send(PS2_CMD_SET_LEDS);
    dev_frame(4, 1'b0, line);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_lines", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'd0);
    repeat (100) @(negedge clk);
    check_eq("rst_mid_no_done", 32'(done_cnt - start), 32'd0);
    run_txn(PS2_CMD_ECHO, 1'b0, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
